// File: rtl/dff_and_demux_if.sv
// Bus bundle for dff_and_demux: lane-tagged write port, packed frame output and sticky errors.
interface dff_and_demux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
);
    localparam int unsigned SEL_W = $clog2(LANES);

    logic [WIDTH-1:0]       d;
    logic [SEL_W-1:0]       sel;
    logic                   wr_en;
    logic                   in_ready;
    logic [WIDTH*LANES-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   dup_err;
    logic                   ovf_err;

    modport master (
        output d, sel, wr_en, out_ready,
        input  in_ready, out_data, out_valid, dup_err, ovf_err
    );

    modport slave (
        input  d, sel, wr_en, out_ready,
        output in_ready, out_data, out_valid, dup_err, ovf_err
    );
endinterface

// File: rtl/dff_and_demux.sv
// Demultiplexes lane-tagged values into LANES registers and emits the packed frame on valid/ready.
// Optional macro DFF_DEMUX_LANE_OUT_EN exposes the live lane registers on q_lanes.
module dff_and_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef DFF_DEMUX_LANE_OUT_EN
    output logic [WIDTH*LANES-1:0] q_lanes,
`endif
    dff_and_demux_if.slave         bus
);

    typedef enum logic [1:0] {StIdle, StFill, StPend} state_e;

    state_e                        state_q, state_d;
    logic [LANES-1:0][WIDTH-1:0]   lanes_q, lanes_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [LANES-1:0]              new_mask;
    logic [WIDTH*LANES-1:0]        out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          dup_err_q, dup_err_d;
    logic                          ovf_err_q, ovf_err_d;
    logic                          in_ready;
    logic                          accept;

    // A full mask only persists while a completed frame waits behind a stalled output.
    assign in_ready = !((&mask_q) && out_valid_q && !bus.out_ready);
    assign accept   = bus.wr_en && in_ready;

    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        dup_err_d   = dup_err_q;
        ovf_err_d   = ovf_err_q;
        new_mask    = mask_q;
        new_mask[bus.sel] = 1'b1;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (bus.wr_en && !in_ready)       ovf_err_d   = 1'b1;
        if (accept)                       lanes_d[bus.sel] = bus.d;

        case (state_q)
            StPend: begin
                if (bus.out_ready) begin
                    out_data_d  = lanes_q;
                    out_valid_d = 1'b1;
                    mask_d      = '0;
                    state_d     = StIdle;
                    // A write on the release edge starts the next frame.
                    if (accept) begin
                        mask_d[bus.sel] = 1'b1;
                        state_d         = StFill;
                    end
                end
            end
            default: begin
                if (accept) begin
                    if (mask_q[bus.sel]) dup_err_d = 1'b1;
                    if (&new_mask) begin
                        if (!out_valid_q || bus.out_ready) begin
                            out_data_d  = lanes_d;
                            out_valid_d = 1'b1;
                            mask_d      = '0;
                            state_d     = StIdle;
                        end else begin
                            mask_d  = new_mask;
                            state_d = StPend;
                        end
                    end else begin
                        mask_d  = new_mask;
                        state_d = StFill;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lanes_q     <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            dup_err_q   <= dup_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dup_err   = dup_err_q;
    assign bus.ovf_err   = ovf_err_q;

`ifdef DFF_DEMUX_LANE_OUT_EN
    assign q_lanes = lanes_q;
`endif

endmodule

// File: tb/tb_dff_and_demux.sv
// Directed bench for dff_and_demux: vector table for framing/stall/errors, then reset and streaming.
module tb_dff_and_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dff_and_demux_if #(.WIDTH(8), .LANES(4)) bus ();

`ifdef DFF_DEMUX_LANE_OUT_EN
    logic [31:0] q_lanes;
`endif

    dff_and_demux #(.WIDTH(8), .LANES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef DFF_DEMUX_LANE_OUT_EN
        .q_lanes(q_lanes),
`endif
        .bus    (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [31:0] data;
        logic        dup;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int checks = 0;
    int failures = 0;
    int frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sel, input logic [7:0] d,
                         input logic ordy);
        @(negedge clk);
        bus.wr_en     = wr;
        bus.sel       = sel;
        bus.d         = d;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] exp_frame;

        bus.wr_en     = 1'b0;
        bus.sel       = '0;
        bus.d         = '0;
        bus.out_ready = 1'b0;

        //          wr   sel   d      ordy  ir    ov    data          dup   ovf
        vecs[0]  = '{1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 8'h33, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 8'h44, 1'b1, 1'b1, 1'b1, 32'h44332211, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 8'hA0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 8'hB0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 8'hC0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 8'hD0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 8'hE0, 1'b1, 1'b1, 1'b1, 32'hD0C0E0B0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 32'hD0C0E0B0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0, 32'hD0C0E0B0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 8'h22, 1'b0, 1'b1, 1'b0, 32'hD0C0E0B0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 8'h33, 1'b0, 1'b1, 1'b0, 32'hD0C0E0B0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 2'd3, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 2'd0, 8'h55, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 2'd1, 8'h66, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 2'd2, 8'h77, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 2'd3, 8'h88, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 2'd0, 8'h99, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h88776655, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h88776655, 1'b1, 1'b1};

        // Reset values while held in reset.
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_dup_err",   32'(bus.dup_err),   32'd0);
        check("rst_ovf_err",   32'(bus.ovf_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].wr, vecs[i].sel, vecs[i].d, vecs[i].ordy);
            check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].ir));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_out_data", i),  bus.out_data,       vecs[i].data);
            check($sformatf("vec%0d_dup_err", i),   32'(bus.dup_err),   32'(vecs[i].dup));
            check($sformatf("vec%0d_ovf_err", i),   32'(bus.ovf_err),   32'(vecs[i].ovf));
        end

        // Build a held frame plus a pending one, then reset asynchronously between edges.
        for (int i = 0; i < 8; i++) drive(1'b1, i[1:0], 8'(i + 1), 1'b0);
        check("pend_in_ready", 32'(bus.in_ready), 32'd0);
        check("pend_out_data", bus.out_data, 32'h04030201);
        @(negedge clk);
        bus.wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_out_data",  bus.out_data,       32'd0);
        check("async_rst_dup_err",   32'(bus.dup_err),   32'd0);
        check("async_rst_ovf_err",   32'(bus.ovf_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DFF_DEMUX_LANE_OUT_EN
        drive(1'b1, 2'd1, 8'h5A, 1'b1);
        check("q_lanes_route", q_lanes, 32'h00005A00);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Streaming: one frame every four writes, each visible for exactly one cycle.
        for (int j = 0; j < 256; j++) begin
            drive(1'b1, j[1:0], j[7:0], 1'b1);
            if (bus.out_valid) frames_seen++;
            check($sformatf("b2b%0d_in_ready", j), 32'(bus.in_ready), 32'd1);
            if (j[1:0] == 2'd3) begin
                b = j[7:0];
                exp_frame = {b, b - 8'd1, b - 8'd2, b - 8'd3};
                check($sformatf("b2b%0d_out_valid", j), 32'(bus.out_valid), 32'd1);
                check($sformatf("b2b%0d_out_data", j),  bus.out_data,       exp_frame);
            end else begin
                check($sformatf("b2b%0d_out_valid", j), 32'(bus.out_valid), 32'd0);
            end
        end
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        check("b2b_drain_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_frames",      32'(frames_seen),   32'd64);
        check("b2b_dup_err",     32'(bus.dup_err),   32'd0);
        check("b2b_ovf_err",     32'(bus.ovf_err),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_and_demux.md
Name: dff_and_demux

Overview:
- Receive-side counterpart of the registered byte mux. A stream of WIDTH-bit values, each tagged with a lane select, is demultiplexed into LANES holding registers.
- When every lane has been written once, the block packs the lanes into one frame word and presents it on a valid/ready output port.
- It sits downstream of the mux path and rebuilds the wide word that the mux serialised.

Parameters:
- WIDTH, 8, bits per lane / input value.
- LANES, 4, number of lanes. Must be a power of two and ≥ 2. SEL_W = $clog2(LANES), which is 2 by default.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  WIDTH  input value.
- sel  in  SEL_W  destination lane for d.
- wr_en  in  1  write strobe; d/sel are sampled on a rising clk edge while wr_en=1.
- in_ready  out  1  block can accept a write this cycle.
- out_data  out  WIDTH*LANES  packed frame; lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds an unconsumed frame.
- out_ready  in  1  downstream accepts the frame.
- dup_err  out  1  sticky: a lane was rewritten before its frame completed.
- ovf_err  out  1  sticky: a write arrived while in_ready=0.

Behaviour:
- Reset (async assert, sync release):
  - All lane registers, fill mask[LANES-1:0] and out_data go to 0.
  - out_valid, dup_err and ovf_err go to 0; in_ready goes to 1.
- Accepted write (wr_en=1 and in_ready=1):
  - lane[sel] <= d; mask[sel] <= 1.
  - If mask[sel] was already 1: the lane is overwritten (last value wins) and dup_err <= 1.
- in_ready = !(mask all ones && out_valid && !out_ready). This is combinational from registered state and out_ready.
- Rejected write (wr_en=1 and in_ready=0): d is dropped, no state changes, ovf_err <= 1.
- FSM, derived from mask and out_valid:
  - IDLE (mask=0): an accepted write goes to FILL.
  - FILL (mask partial): each accepted write sets its mask bit. The write that sets the last missing bit completes the frame.
  - Completion with the output free (out_valid=0, or out_ready=1 on that edge):
    - on the same edge, out_data <= all lanes including the completing value;
    - out_valid <= 1; mask <= 0; go to IDLE.
    - Latency: frame visible on out_data the cycle after the last write.
  - Completion while the output is stalled (out_valid=1, out_ready=0):
    - lanes are updated, mask becomes all ones, go to PEND.
  - PEND (mask full, awaiting output):
    - in_ready=0.
    - On the first edge with out_ready=1: out_data <= lanes, out_valid stays 1, mask <= 0, go to IDLE.
- Output handshake:
  - The frame transfers on an edge where out_valid=1 and out_ready=1.
  - out_valid falls on that edge unless a new frame is loaded on the same edge, in which case it stays 1 (back-to-back frames, no bubble).
  - out_data is stable while out_valid=1 and out_ready=0.
- Lane registers are not cleared after capture. A new frame overwrites them.
- dup_err and ovf_err clear only on reset.
- Reset mid-frame or mid-PEND discards the partial frame and any pending frame immediately.
- sel is always in range because LANES is a power of two.

Optional Feature:
- Macro DFF_DEMUX_LANE_OUT_EN.
- When defined: adds output q_lanes (WIDTH*LANES), which is the live lane registers, updated the cycle after each accepted write and reset to 0. Used to probe demux routing directly.
- When undefined: the port and its logic are absent, and only the frame port is observable.

Test Plan:
- Reset: rst_n=0 mid-operation -> all outputs 0 and in_ready=1 immediately, without waiting for a clk edge.
- In-order frame: writes sel=0..3 with d=11,22,33,44 and out_ready=1 -> next cycle out_valid=1 and out_data=32'h44332211; the next cycle out_valid=0.
- Out-of-order and duplicate: sel order 2,0,2,3,1 with d=A0,B0,C0,D0,E0 -> out_data=32'hD0C0E0B0 and dup_err=1.
- Stall:
  - out_ready=0 holds frame 32'h44332211.
  - Write a second frame 55..88 -> in_ready=0 after its 4th write.
  - A 5th write -> ovf_err=1.
  - Raise out_ready -> next cycle out_data=32'h88776655 with no bubble.
- Back-to-back: 256 writes with d=j, sel=j[1:0], out_ready=1 -> 64 frames, frame n = {4n+3,4n+2,4n+1,4n}, no errors.
- With DFF_DEMUX_LANE_OUT_EN: write sel=1, d=5A -> q_lanes[15:8]=5A the next cycle, other lanes unchanged.
